box_motion_arbiter: RTL and testbench

//  Frame-synchronous controller that owns the on-screen box position used by the VGA overlay.
//  Two requesters compete for one position update per frame: the board push-buttons and PS/2 WASD keys.

---
 rtl/motion_pkg.sv | 68 ++++++
 rtl/box_motion_arbiter_if.sv | 24 ++
 rtl/ps2_dir_decoder.sv | 32 +++
 rtl/box_motion_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_box_motion_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Shared types and constants for the box motion arbiter: direction bit indices,
// PS/2 scancodes, FSM states, grant encodings and the per-axis clamp helper.
package motion_pkg;

  // Direction vector layout is {u, r, d, l}.
  localparam int DIR_U = 3;
  localparam int DIR_R = 2;
  localparam int DIR_D = 1;
  localparam int DIR_L = 0;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef logic [3:0] dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    STEP_X = 2'd2,
    STEP_Y = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_BTN  = 2'b01,
    SRC_KBD  = 2'b10
  } grant_src_t;

  // Unknown codes map to an empty vector, so callers need no separate "known" flag.
  function automatic dir_t scancode_to_dir(input logic [7:0] code);
    dir_t d;
    d = '0;
    case (code)
      SC_W:    d[DIR_U] = 1'b1;
      SC_A:    d[DIR_L] = 1'b1;
      SC_S:    d[DIR_D] = 1'b1;
      SC_D:    d[DIR_R] = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  // One axis step with border clamp; fwd/back both set cancel out.
  function automatic logic [10:0] step_axis(
    input logic [10:0] pos,
    input logic [10:0] step,
    input logic        fwd,
    input logic        back,
    input logic [10:0] lo,
    input logic [10:0] hi,
    input logic [10:0] size
  );
    logic [10:0] nx;
    nx = pos;
    if (fwd && !back) begin
      nx = pos + step;
      if (nx + size >= hi) nx = hi - size - 11'd1;
    end else if (back && !fwd) begin
      nx = (pos < lo + step) ? lo : pos - step;
    end
    return nx;
  endfunction

endpackage

// File: rtl/box_motion_arbiter_if.sv
// Input requests and box position outputs of the box motion arbiter.
interface box_motion_arbiter_if;
  logic       screen_end;
  logic       btn_u;
  logic       btn_r;
  logic       btn_d;
  logic       btn_l;
  logic       ps2_valid;
  logic [7:0] ps2_code;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [1:0] grant_src;
  logic       moving;

  modport master (
    output screen_end, btn_u, btn_r, btn_d, btn_l, ps2_valid, ps2_code,
    input  box_x, box_y, grant_src, moving
  );

  modport slave (
    input  screen_end, btn_u, btn_r, btn_d, btn_l, ps2_valid, ps2_code,
    output box_x, box_y, grant_src, moving
  );
endinterface

// File: rtl/ps2_dir_decoder.sv
// Turns the PS/2 scancode byte stream into a held WASD direction vector {u,r,d,l}.
module ps2_dir_decoder
  import motion_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_code,
  output dir_t       held
);

  logic break_armed;
  dir_t hit;

  assign hit = scancode_to_dir(ps2_code);

  // E0 prefixes are transparent; any other non-F0 byte consumes a pending break.
  always_ff @(posedge clk) begin
    if (reset) begin
      held        <= '0;
      break_armed <= 1'b0;
    end else if (ps2_valid) begin
      if (ps2_code == SC_BREAK) begin
        break_armed <= 1'b1;
      end else if (ps2_code != SC_EXT) begin
        held        <= break_armed ? (held & ~hit) : (held | hit);
        break_armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/box_motion_arbiter.sv
// Once-per-frame arbitration between push-buttons and PS/2 WASD, stepping and clamping the box.
// Optional acceleration after a held direction is enabled with `define MOTION_ACCEL_EN.
module box_motion_arbiter
  import motion_pkg::*;
#(
  parameter int X_MIN       = 50,
  parameter int X_MAX       = 480,
  parameter int Y_MIN       = 50,
  parameter int Y_MAX       = 480,
  parameter int BOX_SIZE    = 35,
  parameter int X_INIT      = 100,
  parameter int Y_INIT      = 100,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 16
) (
  input logic                  clk,
  input logic                  reset,
  box_motion_arbiter_if.slave  bus
);

  localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W  = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W  = 11'(Y_MAX);
  localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);

  dir_t        btn_meta;
  dir_t        btn_dir;
  dir_t        kbd_dir;
  logic        screen_end_q;
  logic        start;

  state_t      state;
  state_t      state_nxt;

  grant_src_t  arb_src;
  dir_t        arb_vec;
  logic        ld_arb;
  logic        do_x;
  logic        do_y;
  logic        btn_act;
  logic        kbd_act;

  grant_src_t  grant_src;
  dir_t        gvec;
  logic        rr_kbd;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic [10:0] snap_x;
  logic [10:0] snap_y;
  logic [10:0] step_cur;
  logic [10:0] nx_x;
  logic [10:0] nx_y;
  logic        moving;

  // Two-flop synchroniser for the asynchronous push-buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= '0;
      btn_dir  <= '0;
    end else begin
      btn_meta <= {bus.btn_u, bus.btn_r, bus.btn_d, bus.btn_l};
      btn_dir  <= btn_meta;
    end
  end

  ps2_dir_decoder u_ps2_dir_decoder (
    .clk       (clk),
    .reset     (reset),
    .ps2_valid (bus.ps2_valid),
    .ps2_code  (bus.ps2_code),
    .held      (kbd_dir)
  );

  always_ff @(posedge clk) begin
    if (reset) screen_end_q <= 1'b0;
    else       screen_end_q <= bus.screen_end;
  end

  assign start   = bus.screen_end & ~screen_end_q;
  assign btn_act = |btn_dir;
  assign kbd_act = |kbd_dir;

  // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ARB;
      ARB:     state_nxt = (arb_src == SRC_NONE) ? IDLE : STEP_X;
      STEP_X:  state_nxt = STEP_Y;
      STEP_Y:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arb_src = SRC_NONE;
    arb_vec = '0;
    ld_arb  = 1'b0;
    do_x    = 1'b0;
    do_y    = 1'b0;
    unique case (state)
      ARB: begin
        ld_arb = 1'b1;
        if (btn_act && kbd_act) arb_src = rr_kbd ? SRC_KBD : SRC_BTN;
        else if (btn_act)       arb_src = SRC_BTN;
        else if (kbd_act)       arb_src = SRC_KBD;
        case (arb_src)
          SRC_BTN: arb_vec = btn_dir;
          SRC_KBD: arb_vec = kbd_dir;
          default: arb_vec = '0;
        endcase
      end
      STEP_X:  do_x = 1'b1;
      STEP_Y:  do_y = 1'b1;
      default: ;
    endcase
  end

`ifdef MOTION_ACCEL_EN
  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);

  logic [CNT_W-1:0] hold_cnt;
  dir_t             last_vec;
  logic             fast;

  // hold_cnt is the run length of the previous granted vector; the double step
  // needs that run to be complete before the current (same) vector is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      last_vec <= '0;
      fast     <= 1'b0;
    end else if (ld_arb) begin
      fast     <= (arb_src != SRC_NONE) && (arb_vec == last_vec) && (hold_cnt == HOLD_C);
      last_vec <= arb_vec;
      if (arb_src == SRC_NONE)
        hold_cnt <= '0;
      else if ((arb_vec == last_vec) && (hold_cnt != '0))
        hold_cnt <= (hold_cnt == HOLD_C) ? hold_cnt : hold_cnt + 1'b1;
      else
        hold_cnt <= CNT_W'(1);
    end
  end

  assign step_cur = fast ? (STEP_W << 1) : STEP_W;
`else
  assign step_cur = STEP_W;
`endif

  assign nx_x = step_axis(pos_x, step_cur, gvec[DIR_R], gvec[DIR_L], X_MIN_W, X_MAX_W, BOX_W);
  assign nx_y = step_axis(pos_y, step_cur, gvec[DIR_D], gvec[DIR_U], Y_MIN_W, Y_MAX_W, BOX_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x     <= 11'(X_INIT);
      pos_y     <= 11'(Y_INIT);
      snap_x    <= 11'(X_INIT);
      snap_y    <= 11'(Y_INIT);
      grant_src <= SRC_NONE;
      gvec      <= '0;
      rr_kbd    <= 1'b0;
      moving    <= 1'b0;
    end else begin
      moving <= 1'b0;
      if (ld_arb) begin
        grant_src <= arb_src;
        gvec      <= arb_vec;
        snap_x    <= pos_x;
        snap_y    <= pos_y;
        if (btn_act && kbd_act) rr_kbd <= ~rr_kbd;
      end
      if (do_x) pos_x <= nx_x;
      if (do_y) begin
        pos_y  <= nx_y;
        moving <= (nx_y != snap_y) || (pos_x != snap_x);
      end
    end
  end

  assign bus.box_x     = pos_x[9:0];
  assign bus.box_y     = pos_y[9:0];
  assign bus.grant_src = grant_src;
  assign bus.moving    = moving;

endmodule

// File: tb/tb_box_motion_arbiter.sv
// Self-checking bench for box_motion_arbiter: vector table, directed corner sequences
// and randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_box_motion_arbiter;
  import motion_pkg::*;

  localparam int X_MIN = 50, X_MAX = 480, Y_MIN = 50, Y_MAX = 480;
  localparam int BOX = 35, X_INIT = 100, Y_INIT = 100, STEP = 1, HOLD = 16;

  logic clk = 1'b0;
  logic reset;

  box_motion_arbiter_if bus ();

  box_motion_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int mv_cnt = 0;

  // Reference model state: position, last grant, round-robin and held keys.
  int m_x, m_y, m_src, m_exp_mv;
  bit m_rr_kbd, m_armed;
  bit k_w, k_a, k_s, k_d;
`ifdef MOTION_ACCEL_EN
  int         m_run;
  logic [3:0] m_last;
`endif

  typedef struct {
    logic [3:0] btn;
    int         ex;
    int         ey;
    int         egs;
    int         emv;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.moving === 1'b1) mv_cnt++;
  endtask

  task automatic model_reset();
    m_x = X_INIT; m_y = Y_INIT; m_src = 0; m_exp_mv = 0;
    m_rr_kbd = 0; m_armed = 0;
    k_w = 0; k_a = 0; k_s = 0; k_d = 0;
`ifdef MOTION_ACCEL_EN
    m_run = 0; m_last = '0;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_armed = 1;
    else if (b != 8'hE0) begin
      case (b)
        8'h1D: k_w = !m_armed;
        8'h1C: k_a = !m_armed;
        8'h1B: k_s = !m_armed;
        8'h23: k_d = !m_armed;
        default: ;
      endcase
      m_armed = 0;
    end
  endtask

  // One frame of the spec's rules: pick a requester, cancel opposites, step, clamp.
  task automatic model_frame(input logic [3:0] b);
    logic [3:0] k, g;
    int step, ox, oy;
    bit fast;
    k = {k_w, k_d, k_s, k_a};
    if (b != 0 && k != 0) begin
      m_src = m_rr_kbd ? 2 : 1;
      m_rr_kbd = !m_rr_kbd;
    end else if (b != 0) m_src = 1;
    else if (k != 0)     m_src = 2;
    else                 m_src = 0;
    g = (m_src == 1) ? b : (m_src == 2) ? k : 4'b0000;
    fast = 0;
`ifdef MOTION_ACCEL_EN
    fast = (m_src != 0) && (g == m_last) && (m_run >= HOLD);
    if (m_src == 0) m_run = 0;
    else if (g == m_last && m_run > 0) m_run = (m_run < HOLD) ? m_run + 1 : HOLD;
    else m_run = 1;
    m_last = g;
`endif
    step = fast ? 2 * STEP : STEP;
    ox = m_x; oy = m_y;
    if (g[2] && !g[0])      m_x = (m_x + step > X_MAX - BOX - 1) ? X_MAX - BOX - 1 : m_x + step;
    else if (g[0] && !g[2]) m_x = (m_x - step < X_MIN) ? X_MIN : m_x - step;
    if (g[1] && !g[3])      m_y = (m_y + step > Y_MAX - BOX - 1) ? Y_MAX - BOX - 1 : m_y + step;
    else if (g[3] && !g[1]) m_y = (m_y - step < Y_MIN) ? Y_MIN : m_y - step;
    m_exp_mv = (m_x != ox || m_y != oy) ? 1 : 0;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {bus.btn_u, bus.btn_r, bus.btn_d, bus.btn_l} = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.ps2_code  = b;
    bus.ps2_valid = 1'b1;
    tick();
    bus.ps2_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.screen_end = 1'b0;
    bus.ps2_valid  = 1'b0;
    bus.ps2_code   = 8'h00;
    set_btn(4'b0000);
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  // Buttons settle through the synchroniser, then a 4-clk screen_end pulse; an
  // optional PS/2 byte is strobed on the same clk as the rising edge.
  task automatic run_frame(input logic [3:0] b, input bit with_byte, input logic [7:0] byt,
                           input string tag);
    set_btn(b);
    repeat (3) tick();
    mv_cnt = 0;
    bus.screen_end = 1'b1;
    if (with_byte) begin
      bus.ps2_code  = byt;
      bus.ps2_valid = 1'b1;
    end
    tick();
    bus.ps2_valid = 1'b0;
    if (with_byte) model_byte(byt);
    repeat (3) tick();
    bus.screen_end = 1'b0;
    repeat (4) tick();
    model_frame(b);
    check({tag, " box_x"}, int'(bus.box_x), m_x);
    check({tag, " box_y"}, int'(bus.box_y), m_y);
    check({tag, " grant_src"}, int'(bus.grant_src), m_src);
    check({tag, " moving"}, mv_cnt, m_exp_mv);
  endtask

  initial begin
    int tot_mv;
    int gs_seq[4];
    logic [7:0] pool[8];

    vt[0] = '{4'b0000, 100, 100, 0, 0};
    vt[1] = '{4'b0100, 101, 100, 1, 1};
    vt[2] = '{4'b1000, 101,  99, 1, 1};
    vt[3] = '{4'b1010, 101,  99, 1, 0};
    vt[4] = '{4'b0101, 101,  99, 1, 0};
    vt[5] = '{4'b1100, 102,  98, 1, 1};
    vt[6] = '{4'b0011, 101,  99, 1, 1};
    vt[7] = '{4'b1111, 101,  99, 1, 0};
    vt[8] = '{4'b0000, 101,  99, 0, 0};

    do_reset();
    check("reset box_x", int'(bus.box_x), 100);
    check("reset box_y", int'(bus.box_y), 100);
    check("reset grant_src", int'(bus.grant_src), 0);
    check("reset moving", int'(bus.moving), 0);

    for (int i = 0; i < 9; i++) begin
      run_frame(vt[i].btn, 0, 8'h00, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_x", i), int'(bus.box_x), vt[i].ex);
      check($sformatf("vec%0d tbl_y", i), int'(bus.box_y), vt[i].ey);
      check($sformatf("vec%0d tbl_gs", i), int'(bus.grant_src), vt[i].egs);
      check($sformatf("vec%0d tbl_mv", i), mv_cnt, vt[i].emv);
    end

    // Held right button for ten frames.
    do_reset();
    tot_mv = 0;
    for (int i = 0; i < 10; i++) begin
      run_frame(4'b0100, 0, 8'h00, "btn_r");
      tot_mv += mv_cnt;
    end
    check("btn_r x", int'(bus.box_x), 110);
    check("btn_r y", int'(bus.box_y), 100);
    check("btn_r gs", int'(bus.grant_src), 1);
    check("btn_r pulses", tot_mv, 10);

    // W held for three frames, then released.
    send_byte(8'h1D);
    for (int i = 0; i < 3; i++) begin
      run_frame(4'b0000, 0, 8'h00, "key_w");
      check("key_w gs", int'(bus.grant_src), 2);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
    run_frame(4'b0000, 0, 8'h00, "key_w_rel");
    check("key_w_rel y", int'(bus.box_y), 97);
    check("key_w_rel gs", int'(bus.grant_src), 0);

    // Both requesters active: round-robin must alternate starting with buttons.
    send_byte(8'h23);
    gs_seq = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) begin
      run_frame(4'b0001, 0, 8'h00, "rr");
      check($sformatf("rr gs%0d", i), int'(bus.grant_src), gs_seq[i]);
      check($sformatf("rr x%0d", i), int'(bus.box_x), (i % 2 == 0) ? 109 : 110);
    end
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h23);
    run_frame(4'b0000, 0, 8'h00, "rr_rel");

    // Right border saturation.
    for (int i = 0; i < 400 && m_x < X_MAX - BOX - 1; i++)
      run_frame(4'b0100, 0, 8'h00, "to_right");
    for (int i = 0; i < 5; i++) begin
      run_frame(4'b0100, 0, 8'h00, "clamp_r");
      check("clamp_r x", int'(bus.box_x), 444);
      check("clamp_r mv", mv_cnt, 0);
    end

    // Top border from y=51.
    for (int i = 0; i < 100 && m_y > Y_MIN + 1; i++)
      run_frame(4'b1000, 0, 8'h00, "to_top");
    check("at y51", int'(bus.box_y), 51);
    run_frame(4'b1000, 0, 8'h00, "clamp_u");
    check("clamp_u y", int'(bus.box_y), 50);
    for (int i = 0; i < 3; i++) begin
      run_frame(4'b1000, 0, 8'h00, "clamp_u_hold");
      check("clamp_u_hold y", int'(bus.box_y), 50);
      check("clamp_u_hold mv", mv_cnt, 0);
    end

    // A second rising edge while the update is in flight is dropped.
    set_btn(4'b0010);
    repeat (3) tick();
    mv_cnt = 0;
    bus.screen_end = 1'b1; tick();
    bus.screen_end = 1'b0; tick();
    bus.screen_end = 1'b1; tick(); tick();
    bus.screen_end = 1'b0;
    repeat (8) tick();
    model_frame(4'b0010);
    check("drop y", int'(bus.box_y), 51);
    check("drop mv", mv_cnt, 1);

    // Opposing vertical buttons cancel.
    run_frame(4'b1010, 0, 8'h00, "cancel_ud");
    check("cancel_ud y", int'(bus.box_y), 51);
    check("cancel_ud mv", mv_cnt, 0);

    // Reset while the FSM sits in STEP_X.
    set_btn(4'b0001);
    repeat (3) tick();
    bus.screen_end = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    bus.screen_end = 1'b0;
    tick();
    check("rst_stepx x", int'(bus.box_x), 100);
    check("rst_stepx y", int'(bus.box_y), 100);
    check("rst_stepx gs", int'(bus.grant_src), 0);
    set_btn(4'b0000);
    tick();
    reset = 1'b0;
    model_reset();
    tick();

    // PS/2 make on the same clk as the frame edge counts this frame.
    run_frame(4'b0000, 1, 8'h1B, "same_clk");
    check("same_clk y", int'(bus.box_y), 101);
    check("same_clk gs", int'(bus.grant_src), 2);

`ifdef MOTION_ACCEL_EN
    do_reset();
    for (int i = 0; i < 20; i++) run_frame(4'b0100, 0, 8'h00, "accel");
    check("accel x", int'(bus.box_x), 124);
    run_frame(4'b0000, 0, 8'h00, "accel_idle");
    run_frame(4'b0100, 0, 8'h00, "accel_again");
    check("accel_again x", int'(bus.box_x), 125);
`endif

    // Randomized frames with interleaved PS/2 traffic.
    do_reset();
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hF0, 8'hE0, 8'h00};
    for (int i = 0; i < 200; i++) begin
      int nb;
      logic [3:0] b;
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) begin
        logic [7:0] byt;
        int sel;
        sel = $urandom_range(0, 7);
        byt = (sel == 7) ? 8'($urandom_range(0, 255)) : pool[sel];
        send_byte(byt);
      end
      b = 4'($urandom) & 4'($urandom);
      run_frame(b, 0, 8'h00, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
